// File: rtl/led_pattern_shifter.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_shifter
// Brief    : Parametrised LED pattern generator with an integrated step-rate
//            prescaler. Pattern modes are Johnson, ring, bounce and hold, with
//            enable, parallel load and a registered step strobe.
// Options  : define LED_PATTERN_STEP_CNT_EN to add the step_cnt output
//            (steps modulo 2*WIDTH).
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_shifter #(
  parameter  int WIDTH  = 8,
  parameter  int DIV    = 50000000,
  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1,
  localparam int STEP_W = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             lr,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tick
`ifdef LED_PATTERN_STEP_CNT_EN
  ,
  output logic [STEP_W-1:0] step_cnt
`endif
);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
  localparam logic [1:0]       MODE_JOHN  = 2'b00;
  localparam logic [1:0]       MODE_RING  = 2'b01;
  localparam logic [1:0]       MODE_BOUNCE = 2'b10;
  localparam logic [WIDTH-1:0] SEED       = WIDTH'(1);

  logic [CNT_W-1:0] div_cnt;
  logic             dir;        // bounce direction: 0 = toward MSB, 1 = toward bit 0
  logic             step;
  logic [WIDTH-1:0] q_next;
  logic             dir_next;

  // A step happens on the edge where an enabled prescaler wraps.
  assign step = en && (div_cnt == DIV_LAST);

  // Next pattern value for the current mode, evaluated from the present q.
  always_comb begin
    q_next   = q;
    dir_next = dir;
    case (mode)
      MODE_JOHN: begin
        if (lr) q_next = {~q[0], q[WIDTH-1:1]};
        else    q_next = {q[WIDTH-2:0], ~q[WIDTH-1]};
      end
      MODE_RING: begin
        // An all-zero ring would never light anything, so reseed it.
        if (q == '0)  q_next = SEED;
        else if (lr)  q_next = {q[0], q[WIDTH-1:1]};
        else          q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      end
      MODE_BOUNCE: begin
        // Anything other than a single lit bit restarts the bounce from bit 0.
        if (!$onehot(q)) begin
          q_next   = SEED;
          dir_next = 1'b0;
        end else if (!dir) begin
          if (q[WIDTH-1]) begin
            dir_next = 1'b1;
            q_next   = q >> 1;
          end else begin
            q_next   = q << 1;
          end
        end else begin
          if (q[0]) begin
            dir_next = 1'b0;
            q_next   = q << 1;
          end else begin
            q_next   = q >> 1;
          end
        end
      end
      default: q_next = q;  // hold
    endcase
  end

  // Prescaler, pattern register, bounce direction and step strobe; load wins over a step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      q       <= '0;
      dir     <= 1'b0;
      tick    <= 1'b0;
    end else if (load) begin
      div_cnt <= '0;
      q       <= load_val;
      dir     <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= step;
      if (en) begin
        if (div_cnt == DIV_LAST) div_cnt <= '0;
        else                     div_cnt <= div_cnt + 1'b1;
      end
      if (step) begin
        q   <= q_next;
        dir <= dir_next;
      end
    end
  end

`ifdef LED_PATTERN_STEP_CNT_EN
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(2 * WIDTH - 1);

  // Step counter modulo 2*WIDTH, cleared by load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
    end else if (load) begin
      step_cnt <= '0;
    end else if (step) begin
      if (step_cnt == STEP_LAST) step_cnt <= '0;
      else                       step_cnt <= step_cnt + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_shifter
// Brief    : Directed self-checking bench for led_pattern_shifter (WIDTH=8,
//            DIV=4). Expected q values are queued when stimulus is set up and
//            popped as each tick arrives.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_shifter;
  localparam int WIDTH = 8;
  localparam int DIV   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             lr;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tick;
`ifdef LED_PATTERN_STEP_CNT_EN
  logic [3:0]       step_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] held;

  // 10-time-unit system clock.
  always #5 clk = ~clk;

  led_pattern_shifter #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .lr       (lr),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .q        (q),
`ifdef LED_PATTERN_STEP_CNT_EN
    .step_cnt (step_cnt),
`endif
    .tick     (tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop each queued value as its tick arrives; also check the tick spacing.
  task automatic drain(input string tag, input int spacing, input bit wiggle_lr);
    int w;
    logic [WIDTH-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      w = 0;
      do begin
        @(negedge clk);
        w++;
        if (wiggle_lr) lr = ~lr;
      end while (!tick && w < 16);
      check({tag, " q"}, 32'(q), 32'(e));
      check({tag, " gap"}, 32'(w), 32'(spacing));
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; lr = 1'b0; mode = 2'b00; load = 1'b0; load_val = '0;
    repeat (2) @(negedge clk);
    check("reset q", 32'(q), 32'h0);
    check("reset tick", 32'(tick), 32'h0);

    // 1: Johnson, shift left, from zero.
    rst_n = 1'b1; en = 1'b1;
    foreach (exp_q[i]) exp_q.delete(i);
    begin
      logic [WIDTH-1:0] seq [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                     8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
      foreach (seq[i]) exp_q.push_back(seq[i]);
    end
    drain("johnson", 4, 1'b0);

    // 2: ring, shift right, seeded from zero; flip direction at 0x40.
    rst_n = 1'b0;
    @(negedge clk);
    mode = 2'b01; lr = 1'b1; rst_n = 1'b1;
    exp_q.push_back(8'h01); exp_q.push_back(8'h80); exp_q.push_back(8'h40);
    drain("ring_r", 4, 1'b0);
    lr = 1'b0;
    exp_q.push_back(8'h80); exp_q.push_back(8'h01);
    drain("ring_l", 4, 1'b0);

    // 3: bounce from 0x01, lr toggled every cycle.
    load = 1'b1; load_val = 8'h01; mode = 2'b10;
    @(negedge clk);
    load = 1'b0;
    check("load q", 32'(q), 32'h01);
    check("load tick", 32'(tick), 32'h0);
    begin
      logic [WIDTH-1:0] seq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                     8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
      foreach (seq[i]) exp_q.push_back(seq[i]);
    end
    drain("bounce", 4, 1'b1);

    // 4: freeze at div_cnt=2 for 10 clocks, then resume.
    repeat (2) @(negedge clk);
    en = 1'b0;
    held = q;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("freeze tick", 32'(tick), 32'h0);
      check("freeze q", 32'(q), 32'(held));
    end
    en = 1'b1;
    exp_q.push_back(8'h04);
    drain("resume", 2, 1'b0);

    // 5: load coincident with a step edge; non-one-hot 0xA5 reseeds bounce.
    repeat (3) @(negedge clk);
    load = 1'b1; load_val = 8'hA5;
    @(negedge clk);
    load = 1'b0;
    check("load_step q", 32'(q), 32'hA5);
    check("load_step tick", 32'(tick), 32'h0);
    exp_q.push_back(8'h01);
    drain("after_load", 4, 1'b0);

    // 6: asynchronous reset pulse between edges while tick is high.
    mode = 2'b00; lr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async q", 32'(q), 32'h0);
    check("async tick", 32'(tick), 32'h0);
    #1 rst_n = 1'b1;
    exp_q.push_back(8'h01); exp_q.push_back(8'h03);
    drain("restart", 4, 1'b0);
`ifdef LED_PATTERN_STEP_CNT_EN
    check("step_cnt", 32'(step_cnt), 32'h2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/led_pattern_shifter.md
Name: led_pattern_shifter

Overview:
- Parametrised LED pattern generator; the next generation of the board-level Johnson-counter LED shifter.
- Integrates the step-rate prescaler, so the block needs no external 1 Hz clock and runs in the single system clock domain.
- Adds selectable pattern modes, enable, parallel load, a step strobe and a configurable width.
- Drives the LED bank directly from the top level.

Parameters:
- WIDTH, 8, number of LEDs / register bits; minimum 2.
- DIV, 50000000, system clk cycles per pattern step; minimum 1.
- CNT_W, $clog2(DIV) (minimum 1), prescaler counter width; derived, do not override.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  1 = prescaler runs; 0 = freeze.
- lr  in  1  direction: 1 = shift right (toward bit 0); 0 = shift left (toward MSB).
- mode  in  2  00 Johnson, 01 ring, 10 bounce, 11 hold.
- load  in  1  synchronous parallel-load strobe.
- load_val  in  WIDTH  value loaded into q.
- q  out  WIDTH  LED pattern, registered.
- tick  out  1  registered one-clk strobe, high in the cycle q takes a new step value.

Behaviour:
- Reset:
  - rst_n=0 immediately clears q, tick, div_cnt and the bounce dir bit to 0.
  - No clock edge is needed.
  - Release takes effect synchronously on the next clk edge.
- Prescaler:
  - If en=1, div_cnt increments each clk.
  - At div_cnt==DIV-1 it wraps to 0 and a step occurs on that edge.
  - If en=0, div_cnt holds and no step occurs.
  - DIV=1: step every clk while en=1.
- tick is registered: it is 1 in exactly the cycle after a step edge, otherwise 0.
- Step rules, where r = q shifted right and l = q shifted left:
  - 00 Johnson, lr=1: q <= {~q[0], q[WIDTH-1:1]}.
  - 00 Johnson, lr=0: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}.
  - 00 Johnson period: 2*WIDTH steps. Any value is legal, including 0.
  - 01 ring, lr=1: q <= {q[0], q[WIDTH-1:1]}.
  - 01 ring, lr=0: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 01 ring: if q==0 at the step, q <= 1 (seed) instead.
  - 10 bounce: a single lit bit ping-pongs; lr is ignored.
  - 10 bounce, dir=0 moves toward the MSB. When q[WIDTH-1]=1 and dir=0, set dir<=1 and shift right on the same step.
  - 10 bounce, dir=1 moves toward bit 0. When q[0]=1 and dir=1, set dir<=0 and shift left on the same step.
  - 10 bounce period: 2*(WIDTH-1) steps.
  - 10 bounce: if q is not one-hot at the step, q <= 1 and dir <= 0.
  - 11 hold: q is unchanged; the prescaler and tick continue normally.
- load=1:
  - Sets q<=load_val, div_cnt<=0 and dir<=0 on that edge.
  - Takes priority over a coincident step; that step is dropped and tick stays 0.
  - load works regardless of en.
- Changes to mode and lr take effect at the next step, using the current q. There is no other sanitisation beyond the seed rules above.
- Latency: q changes on the step edge; tick is high during the following cycle.

Optional Feature:
- Macro: LED_PATTERN_STEP_CNT_EN.
- Defined:
  - Adds output step_cnt, width $clog2(2*WIDTH), reset 0.
  - Increments on every step, modulo 2*WIDTH.
  - Cleared by load and by rst_n.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8, DIV=4):
1. Reset, en=1, mode=00, lr=0:
   - Successive steps give q = 01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00.
   - tick pulses every 4 clks.
2. Reset, mode=01, lr=1:
   - First step gives q=01 (seed), then 80,40,20,...,01,80.
   - Flip lr to 0 while q=40; the next step gives q=80.
3. load_val=01, mode=10:
   - Steps give 02,04,08,10,20,40,80,40,20,10,08,04,02,01,02.
   - Period is 14 steps; lr toggling has no effect.
4. With en=1 and div_cnt=2, drop en for 10 clks, then re-raise it:
   - No tick and q is stable while en=0.
   - The step occurs 2 clks after en returns high.
5. Assert load (load_val=A5) on the step edge:
   - q=A5 and tick=0 in the next cycle.
   - The next step occurs exactly 4 clks later.
6. Pulse rst_n low between clk edges mid-pattern:
   - q=00 and tick=0 before the next edge.
   - After release, mode=00 restarts at q=01 after 4 clks (lr=0).
